seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the memory-mapped 7-segment display register between two requesters, e.g. the CPU store path and a hardware status source.
- Arbitrates write requests round-robin and issues single-cycle write strobes (DIN/WE/address) to the segment peripheral.
- Enforces a minimum display hold time before ownership can change hands.
- Generates a free-running digit-scan tick for the display multiplexer.

Parameters:
- HOLD_CYCLES, 16, cycles a granted value is protected from the other requester (must be >= 1).
- SCAN_DIV, 4, clock cycles per scan_tick pulse (must be >= 2).
- DEFAULT_VAL, 32'h00000000, disp_data value after reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- req0  input  1  requester 0 write request; held until gnt0.
- din0  input  32  requester 0 display value; stable while req0=1.
- gnt0  output  1  one-cycle grant to requester 0.
- req1  input  1  requester 1 write request.
- din1  input  32  requester 1 display value.
- gnt1  output  1  one-cycle grant to requester 1.
- disp_data  output  32  value driven to the segment DIN; registered and retained.
- disp_we  output  1  one-cycle write strobe to the segment WE.
- disp_addr  output  1  segment address select; equals disp_we.
- owner  output  2  last granted requester: 00 none, 01 req0, 10 req1.
- scan_tick  output  1  one-cycle pulse every SCAN_DIV cycles.

Behaviour:
- Reset (reset=0 at a rising edge) sets these values:
  - disp_data=DEFAULT_VAL; gnt0=gnt1=disp_we=disp_addr=scan_tick=0; owner=00.
  - State=IDLE, hold counter=0, scan counter=0.
  - Round-robin pointer last=1, so req0 wins the first tie.
  - Reset applies in any state and discards any pending grant. Requests present during reset are evaluated the first cycle after release.
- All outputs are registered. A request sampled at edge N produces gnt, disp_we and new disp_data during cycle N+1.
- IDLE:
  - No request: stay in IDLE.
  - Only reqX=1: go to GRANT(X).
  - Both requests: go to GRANT of the requester not equal to last.
- GRANT(X), exactly 1 cycle:
  - gntX=1 and disp_we=disp_addr=1.
  - disp_data=dinX is captured at entry. owner=X and last=X are updated.
  - Hold counter loads HOLD_CYCLES-1. Next state is HOLD.
- HOLD, lasting HOLD_CYCLES cycles with the counter decrementing each cycle:
  - Owner rewrite: if req(owner)=1 and req(other)=0, go to GRANT(owner) next cycle. Hold restarts.
  - If req(other)=1, the owner's requests are not served until expiry.
  - Expiry (counter==0): next state follows the IDLE arbitration rules. A tie is won by the non-owner.
- Grant spacing:
  - Between different requesters the minimum is HOLD_CYCLES+1 cycles.
  - With HOLD_CYCLES=1, one HOLD cycle separates grants.
- Requester protocol:
  - A requester deasserts req in the cycle after its gnt.
  - A req still high after gnt counts as a new request.
  - gnt0 and gnt1 are never both 1.
- Outside GRANT, disp_we=0 and disp_data holds its value; the peripheral retains the last written value.
- Scan divider:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - scan_tick=1 in the cycle when the counter equals SCAN_DIV-1.
  - It runs independently of arbitration; disp_we does not reset it.
  - After reset release, the first tick occurs in the SCAN_DIV-th cycle.
- Unused encoding owner=11 and illegal states return to IDLE, owner=00.

Test Plan (HOLD_CYCLES=4, SCAN_DIV=4):
- Reset: reset=0 for 2 cycles with req0=1 -> disp_data=0, owner=00, all strobes 0. First cycle after release: none; second cycle: gnt0=1.
- Single request: req0=1, din0=32'h12345678 at cycle 0 -> cycle 1: gnt0=1, disp_we=1, disp_addr=1, disp_data=32'h12345678, owner=01. Cycles 2-5: disp_we=0 and data held.
- Tie after reset: req0=req1=1, din1=32'hCAFE0001 -> gnt0 at cycle 1, HOLD cycles 2-5, gnt1 at cycle 6 with disp_data=32'hCAFE0001, owner=10.
- Owner rewrite, uncontended: req0 at cycle 3 during HOLD with din0=32'hA5 -> gnt0 at cycle 4 with disp_data=32'hA5; hold restarts, so earliest other grant is cycle 9.
- Contended rewrite: owner=01 in HOLD, req1 and req0 both high -> req0 not served; gnt1 at expiry+1; req0 served after req1's hold.
- Reset mid-HOLD plus scan: reset=0 for one cycle in HOLD -> next cycle everything at reset values and state IDLE. scan_tick pulses at cycles 4, 8, 12 after release, unaffected by grants.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin writer arbitration for the shared 7-segment display register,
// with a post-grant hold window and a free-running digit-scan tick.
module seg_display_arbiter #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned SCAN_DIV    = 4,
   parameter logic [31:0] DEFAULT_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [31:0] din0,
   output logic        gnt0,
   input  logic        req1,
   input  logic [31:0] din1,
   output logic        gnt1,
   output logic [31:0] disp_data,
   output logic        disp_we,
   output logic        disp_addr,
   output logic [1:0]  owner,
   output logic        scan_tick
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_PRE  = SW'(SCAN_DIV - 2);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      HOLD  = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [SW-1:0] scan_q;
   logic          last_q, last_d;
   logic [1:0]    owner_d;
   logic          gnt0_d, gnt1_d, we_d;
   logic [31:0]   data_d;

   logic arb_valid, arb_id;
   logic own_id, own_req, oth_req;
   logic take, take_id;

   // Tie goes to whoever was not served last
   assign arb_valid = req0 | req1;
   assign arb_id    = (req0 & req1) ? ~last_q : req1;

   assign own_id  = owner[1];
   assign own_req = own_id ? req1 : req0;
   assign oth_req = own_id ? req0 : req1;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      last_d  = last_q;
      owner_d = owner;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      we_d    = 1'b0;
      data_d  = disp_data;
      take    = 1'b0;
      take_id = arb_id;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) take = 1'b1;
         end
         GRANT: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (own_req && !oth_req) begin
               take    = 1'b1;
               take_id = own_id;
            end else if (hold_q == '0) begin
               if (arb_valid) take = 1'b1;
               else state_d = IDLE;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = 2'b00;
         end
      endcase
      if (owner == 2'b11) begin
         take    = 1'b0;
         state_d = IDLE;
         owner_d = 2'b00;
      end
      if (take) begin
         state_d = GRANT;
         hold_d  = HOLD_LOAD;
         last_d  = take_id;
         owner_d = take_id ? 2'b10 : 2'b01;
         gnt0_d  = ~take_id;
         gnt1_d  = take_id;
         we_d    = 1'b1;
         data_d  = take_id ? din1 : din0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         last_q    <= 1'b1;
         owner     <= 2'b00;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         disp_we   <= 1'b0;
         disp_data <= DEFAULT_VAL;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         last_q    <= last_d;
         owner     <= owner_d;
         gnt0      <= gnt0_d;
         gnt1      <= gnt1_d;
         disp_we   <= we_d;
         disp_data <= data_d;
      end
   end

   assign disp_addr = disp_we;

   // Tick is registered one count early so it lines up with SCAN_LAST
   always_ff @(posedge clk) begin
      if (!reset) begin
         scan_q    <= '0;
         scan_tick <= 1'b0;
      end else begin
         scan_q    <= (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
         scan_tick <= (scan_q == SCAN_PRE);
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=4, SCAN_DIV=4.
module tb_seg_display_arbiter;

   logic        clk;
   logic        reset;
   logic        req0, req1;
   logic [31:0] din0, din1;
   logic        gnt0, gnt1;
   logic [31:0] disp_data;
   logic        disp_we, disp_addr;
   logic [1:0]  owner;
   logic        scan_tick;

   int checks;
   int errors;

   seg_display_arbiter #(
      .HOLD_CYCLES(4),
      .SCAN_DIV(4),
      .DEFAULT_VAL(32'h0000_0000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req0(req0),
      .din0(din0),
      .gnt0(gnt0),
      .req1(req1),
      .din1(din1),
      .gnt1(gnt1),
      .disp_data(disp_data),
      .disp_we(disp_we),
      .disp_addr(disp_addr),
      .owner(owner),
      .scan_tick(scan_tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in the first cycle after release, requests low
   task automatic do_reset();
      reset = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req0  = 1'b1;
      req1  = 1'b0;
      din0  = 32'h0000_0055;
      step();
      step();
      reset = 1'b1;
      checks++;
      if (disp_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h exp %h", disp_data, 32'h0);
      end
      checks++;
      if ({gnt0, gnt1, disp_we, disp_addr, scan_tick, owner} !== 7'b0) begin
         errors++;
         $display("FAIL reset_strobes got %b exp %b",
                  {gnt0, gnt1, disp_we, disp_addr, scan_tick, owner}, 7'b0);
      end
      step();
      checks++;
      if ({gnt0, gnt1, disp_data} !== {2'b10, 32'h0000_0055}) begin
         errors++;
         $display("FAIL reset_first_gnt got %b%b %h exp 10 00000055",
                  gnt0, gnt1, disp_data);
      end
      req0 = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      req0 = 1'b1;
      din0 = 32'h1234_5678;
      step();
      checks++;
      if ({gnt0, gnt1, disp_we, disp_addr, owner} !== 6'b101101) begin
         errors++;
         $display("FAIL single_gnt got %b exp %b",
                  {gnt0, gnt1, disp_we, disp_addr, owner}, 6'b101101);
      end
      checks++;
      if (disp_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL single_data got %h exp %h", disp_data, 32'h1234_5678);
      end
      req0 = 1'b0;
      din0 = 32'hDEAD_BEEF;
      for (int c = 2; c <= 5; c++) begin
         step();
         checks++;
         if ({disp_we, disp_addr, disp_data} !== {2'b00, 32'h1234_5678}) begin
            errors++;
            $display("FAIL single_hold c%0d got %b %h exp 00 12345678",
                     c, {disp_we, disp_addr}, disp_data);
         end
         checks++;
         if (scan_tick !== (c == 3)) begin
            errors++;
            $display("FAIL single_scan c%0d got %b exp %b",
                     c, scan_tick, (c == 3));
         end
      end
   endtask

   task automatic test_tie();
      do_reset();
      req0 = 1'b1;
      req1 = 1'b1;
      din0 = 32'h1111_1111;
      din1 = 32'hCAFE_0001;
      step();
      checks++;
      if ({gnt0, gnt1, disp_data} !== {2'b10, 32'h1111_1111}) begin
         errors++;
         $display("FAIL tie_first got %b%b %h exp 10 11111111",
                  gnt0, gnt1, disp_data);
      end
      req0 = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         step();
         checks++;
         if ({gnt0, gnt1, disp_we} !== 3'b000) begin
            errors++;
            $display("FAIL tie_hold c%0d got %b exp 000",
                     c, {gnt0, gnt1, disp_we});
         end
      end
      step();
      checks++;
      if ({gnt0, gnt1, owner, disp_data} !== {4'b0110, 32'hCAFE_0001}) begin
         errors++;
         $display("FAIL tie_second got %b%b %b %h exp 01 10 cafe0001",
                  gnt0, gnt1, owner, disp_data);
      end
      req1 = 1'b0;
   endtask

   task automatic test_rewrite();
      do_reset();
      req0 = 1'b1;
      din0 = 32'h0000_0001;
      step();
      req0 = 1'b0;
      step();
      step();
      req0 = 1'b1;
      din0 = 32'h0000_00A5;
      step();
      checks++;
      if ({gnt0, owner, disp_data} !== {3'b101, 32'h0000_00A5}) begin
         errors++;
         $display("FAIL rewrite_gnt got %b %b %h exp 1 01 000000a5",
                  gnt0, owner, disp_data);
      end
      req0 = 1'b0;
      req1 = 1'b1;
      din1 = 32'h0000_0B0B;
      for (int c = 5; c <= 8; c++) begin
         step();
         checks++;
         if (gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL rewrite_block c%0d got %b exp 0", c, gnt1);
         end
      end
      step();
      checks++;
      if ({gnt1, disp_data} !== {1'b1, 32'h0000_0B0B}) begin
         errors++;
         $display("FAIL rewrite_other got %b %h exp 1 00000b0b",
                  gnt1, disp_data);
      end
      req1 = 1'b0;
   endtask

   task automatic test_contended();
      do_reset();
      req0 = 1'b1;
      din0 = 32'h0000_AAAA;
      step();
      req0 = 1'b0;
      step();
      req0 = 1'b1;
      req1 = 1'b1;
      din0 = 32'h0000_BBBB;
      din1 = 32'h0000_CCCC;
      for (int c = 3; c <= 5; c++) begin
         step();
         checks++;
         if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL cont_hold0 c%0d got %b exp 00", c, {gnt0, gnt1});
         end
      end
      step();
      checks++;
      if ({gnt0, gnt1, owner, disp_data} !== {4'b0110, 32'h0000_CCCC}) begin
         errors++;
         $display("FAIL cont_gnt1 got %b%b %b %h exp 01 10 0000cccc",
                  gnt0, gnt1, owner, disp_data);
      end
      req1 = 1'b0;
      for (int c = 7; c <= 10; c++) begin
         step();
         checks++;
         if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL cont_hold1 c%0d got %b exp 00", c, {gnt0, gnt1});
         end
      end
      step();
      checks++;
      if ({gnt0, gnt1, owner, disp_data} !== {4'b1001, 32'h0000_BBBB}) begin
         errors++;
         $display("FAIL cont_gnt0 got %b%b %b %h exp 10 01 0000bbbb",
                  gnt0, gnt1, owner, disp_data);
      end
      req0 = 1'b0;
   endtask

   task automatic test_reset_mid_hold_scan();
      do_reset();
      req0 = 1'b1;
      din0 = 32'h0000_7777;
      step();
      req0 = 1'b0;
      step();
      reset = 1'b0;
      req1  = 1'b1;
      din1  = 32'h0000_9999;
      step();
      checks++;
      if ({gnt0, gnt1, disp_we, scan_tick, owner, disp_data} !== 38'b0) begin
         errors++;
         $display("FAIL midrst_vals got %b%b%b%b %b %h exp all zero",
                  gnt0, gnt1, disp_we, scan_tick, owner, disp_data);
      end
      reset = 1'b1;
      for (int c = 4; c <= 16; c++) begin
         step();
         checks++;
         if (scan_tick !== (c == 6 || c == 10 || c == 14)) begin
            errors++;
            $display("FAIL scan c%0d got %b exp %b",
                     c, scan_tick, (c == 6 || c == 10 || c == 14));
         end
         if (c == 4) begin
            checks++;
            if ({gnt1, owner, disp_data} !== {3'b110, 32'h0000_9999}) begin
               errors++;
               $display("FAIL midrst_idle got %b %b %h exp 1 10 00009999",
                        gnt1, owner, disp_data);
            end
            req1 = 1'b0;
         end
         if (c == 8) begin
            req0 = 1'b1;
            din0 = 32'h0000_4444;
         end
         if (c == 9) begin
            checks++;
            if ({gnt0, disp_data} !== {1'b1, 32'h0000_4444}) begin
               errors++;
               $display("FAIL scan_gnt0 got %b %h exp 1 00004444",
                        gnt0, disp_data);
            end
            req0 = 1'b0;
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clk    = 1'b0;
      reset  = 1'b0;
      req0   = 1'b0;
      req1   = 1'b0;
      din0   = 32'h0;
      din1   = 32'h0;
      test_reset();
      test_single();
      test_tie();
      test_rewrite();
      test_contended();
      test_reset_mid_hold_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
